// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial receive framer.
package serial_rx_pkg;

   // Receiver state encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   // Default frame geometry (matches the downstream fifo word width)
   localparam int DEF_DATA_W       = 10;
   localparam int DEF_CLKS_PER_BIT = 16;
   localparam int DEF_HALF_BIT     = DEF_CLKS_PER_BIT / 2;

   // Number of clocks from the start edge to the middle of a bit
   function automatic int half_bit(input int clks_per_bit);
      return clks_per_bit / 2;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with a caller-supplied reset value.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_rst_val,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // Two-stage capture of the asynchronous input; reset loads the idle value
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= i_rst_val;
         r_sync <= i_rst_val;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/serial_rx_framer.sv
// Serial receiver: 1 start bit, DATA_W data bits LSB first, 1 stop bit.
// Completed frames are pushed into a downstream fifo unless it is full;
// framing errors and dropped frames are flagged with one-cycle pulses.
module serial_rx_framer
   import serial_rx_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              rx,
   input  logic              full,
   output logic              push,
   output logic [DATA_W-1:0] data_out,
   output logic              busy,
   output logic              frame_err,
   output logic              overrun
);

   localparam int TMR_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_W);

   // Terminal counts compared explicitly so neither counter ever wraps
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(half_bit(CLKS_PER_BIT) - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
   localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
   localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

   generate
      if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0)) begin : g_bad_clks
         $error("serial_rx_framer: CLKS_PER_BIT must be even and at least 4");
      end
   endgenerate

   // Synchronised line
   logic              w_rx_s;

   // State and datapath registers
   rx_state_t         r_state;
   logic [TMR_W-1:0]  r_tmr;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_shift;
   logic              r_push;
   logic [DATA_W-1:0] r_data_out;
   logic              r_busy;
   logic              r_frame_err;
   logic              r_overrun;

   // Next-state values
   rx_state_t         w_state_nxt;
   logic [TMR_W-1:0]  w_tmr_nxt;
   logic [IDX_W-1:0]  w_idx_nxt;
   logic [DATA_W-1:0] w_shift_nxt;
   logic              w_push_nxt;
   logic [DATA_W-1:0] w_data_nxt;
   logic              w_frame_err_nxt;
   logic              w_overrun_nxt;

   // The synchroniser resets to 1 so the line looks idle after reset
   sync_2ff #(
      .WIDTH (1)
   ) u_rx_sync (
      .i_clk     (clock),
      .i_rst     (rst),
      .i_rst_val (1'b1),
      .i_d       (rx),
      .o_q       (w_rx_s)
   );

   // Next-state, bit timing, data capture and stop-bit outcome decode
   always_comb begin
      w_state_nxt     = r_state;
      w_tmr_nxt       = r_tmr;
      w_idx_nxt       = r_idx;
      w_shift_nxt     = r_shift;
      w_push_nxt      = 1'b0;
      w_data_nxt      = r_data_out;
      w_frame_err_nxt = 1'b0;
      w_overrun_nxt   = 1'b0;

      case (r_state)
         IDLE: begin
            w_tmr_nxt = TMR_ZERO;
            w_idx_nxt = IDX_ZERO;
            if (w_rx_s == 1'b0) begin
               w_state_nxt = START;
            end else begin
               w_state_nxt = IDLE;
            end
         end

         START: begin
            if (r_tmr == HALF_LAST) begin
               w_tmr_nxt = TMR_ZERO;
               w_idx_nxt = IDX_ZERO;
               if (w_rx_s == 1'b1) begin
                  // Line went back high before mid-start: a glitch, not a frame
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DATA;
               end
            end else begin
               w_tmr_nxt = r_tmr + TMR_ONE;
            end
         end

         DATA: begin
            if (r_tmr == TMR_LAST) begin
               w_tmr_nxt   = TMR_ZERO;
               // Shifting in from the top leaves bit 0 in the LSB after DATA_W samples
               w_shift_nxt = {w_rx_s, r_shift[DATA_W-1:1]};
               if (r_idx == IDX_LAST) begin
                  w_idx_nxt   = IDX_ZERO;
                  w_state_nxt = STOP;
               end else begin
                  w_idx_nxt = r_idx + IDX_ONE;
               end
            end else begin
               w_tmr_nxt = r_tmr + TMR_ONE;
            end
         end

         STOP: begin
            if (r_tmr == TMR_LAST) begin
               // Leave at mid-stop so an immediately following start edge is caught
               w_tmr_nxt   = TMR_ZERO;
               w_state_nxt = IDLE;
               if (w_rx_s == 1'b0) begin
                  w_frame_err_nxt = 1'b1;
               end else if (full == 1'b1) begin
                  w_overrun_nxt = 1'b1;
               end else begin
                  w_push_nxt = 1'b1;
                  w_data_nxt = r_shift;
               end
            end else begin
               w_tmr_nxt = r_tmr + TMR_ONE;
            end
         end

         default: begin
            w_state_nxt = IDLE;
            w_tmr_nxt   = TMR_ZERO;
            w_idx_nxt   = IDX_ZERO;
         end
      endcase
   end

   // State, counters, shift register and registered outputs
   always_ff @(posedge clock) begin
      if (rst) begin
         r_state     <= IDLE;
         r_tmr       <= TMR_ZERO;
         r_idx       <= IDX_ZERO;
         r_shift     <= {DATA_W{1'b0}};
         r_push      <= 1'b0;
         r_data_out  <= {DATA_W{1'b0}};
         r_busy      <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_tmr       <= w_tmr_nxt;
         r_idx       <= w_idx_nxt;
         r_shift     <= w_shift_nxt;
         r_push      <= w_push_nxt;
         r_data_out  <= w_data_nxt;
         r_busy      <= (w_state_nxt != IDLE);
         r_frame_err <= w_frame_err_nxt;
         r_overrun   <= w_overrun_nxt;
      end
   end

   assign push      = r_push;
   assign data_out  = r_data_out;
   assign busy      = r_busy;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_serial_rx_framer.sv
// Directed bench for serial_rx_framer with CLKS_PER_BIT=8, DATA_W=10.
module tb_serial_rx_framer;

   localparam int CPB   = 8;
   localparam int DW    = 10;
   localparam int FRAME = CPB * 12;

   logic          clock = 1'b0;
   logic          rst   = 1'b1;
   logic          rx    = 1'b1;
   logic          full  = 1'b0;
   logic          push;
   logic [DW-1:0] data_out;
   logic          busy;
   logic          frame_err;
   logic          overrun;

   int            cyc     = 0;
   int            n_push  = 0;
   int            n_ferr  = 0;
   int            n_ovr   = 0;
   int            n_busy  = 0;
   int            n_pass  = 0;
   int            n_total = 0;
   logic [DW-1:0] pq_data[$];
   int            pq_cyc[$];

   serial_rx_framer #(
      .DATA_W       (DW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clock     (clock),
      .rst       (rst),
      .rx        (rx),
      .full      (full),
      .push      (push),
      .data_out  (data_out),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   // 10 ns clock
   always #5 clock = ~clock;

   // Cycle counter, one tick per rising edge
   always @(posedge clock) cyc <= cyc + 1;

   // Output monitor sampled on the falling edge, away from the active edge
   always @(negedge clock) begin
      if (push) begin
         n_push <= n_push + 1;
         pq_data.push_back(data_out);
         pq_cyc.push_back(cyc);
      end
      if (frame_err) n_ferr <= n_ferr + 1;
      if (overrun)   n_ovr  <= n_ovr + 1;
      if (busy)      n_busy <= n_busy + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
   endtask

   // Drive the first ncyc clocks of a 12-bit frame image (bit 0 first)
   task automatic send_raw(input logic [11:0] bits, input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         rx = bits[k / CPB];
         @(negedge clock);
      end
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit);
      send_raw({stop_bit, d, 1'b0}, FRAME);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   initial begin
      int p0, f0, o0, b0, t0, q0;

      // ---- reset values ----
      repeat (3) @(negedge clock);
      check("rst_push",  32'(push),      32'h0);
      check("rst_data",  32'(data_out),  32'h0);
      check("rst_busy",  32'(busy),      32'h0);
      check("rst_ferr",  32'(frame_err), 32'h0);
      check("rst_ovr",   32'(overrun),   32'h0);
      rst = 1'b0;
      idle(6);

      // ---- clean frame 0x2A5 ----
      p0 = n_push; f0 = n_ferr; o0 = n_ovr; b0 = n_busy; q0 = pq_data.size();
      t0 = cyc + 1;
      send_frame(10'h2A5, 1'b1);
      idle(6);
      check("clean_push_cnt", 32'(n_push - p0), 32'd1);
      check("clean_data",     32'(pq_data[q0]), 32'h2A5);
      check("clean_latency",  32'((pq_cyc[q0] - t0 >= 94) && (pq_cyc[q0] - t0 <= 96)), 32'd1);
      check("clean_ferr",     32'(n_ferr - f0), 32'd0);
      check("clean_ovr",      32'(n_ovr - o0),  32'd0);
      check("clean_busy_len", 32'(n_busy - b0), 32'd92);

      // ---- glitch: 3 cycles low ----
      p0 = n_push; f0 = n_ferr; b0 = n_busy;
      rx = 1'b0;
      repeat (3) @(negedge clock);
      rx = 1'b1;
      repeat (5) @(negedge clock);
      check("glitch_busy_low", 32'(busy), 32'h0);
      idle(20);
      check("glitch_busy_len", 32'(n_busy - b0), 32'd4);
      check("glitch_push",     32'(n_push - p0), 32'd0);
      check("glitch_ferr",     32'(n_ferr - f0), 32'd0);

      // ---- stop bit low: 0x155 ----
      p0 = n_push; f0 = n_ferr; o0 = n_ovr;
      send_frame(10'h155, 1'b0);
      idle(30);
      check("ferr_pulse",     32'(n_ferr - f0), 32'd1);
      check("ferr_no_push",   32'(n_push - p0), 32'd0);
      check("ferr_no_ovr",    32'(n_ovr - o0),  32'd0);
      check("ferr_data_hold", 32'(data_out),    32'h2A5);

      // ---- full held: 0x3FF dropped ----
      p0 = n_push; f0 = n_ferr; o0 = n_ovr;
      full = 1'b1;
      send_frame(10'h3FF, 1'b1);
      idle(10);
      check("ovr_pulse",     32'(n_ovr - o0),  32'd1);
      check("ovr_no_push",   32'(n_push - p0), 32'd0);
      check("ovr_no_ferr",   32'(n_ferr - f0), 32'd0);
      check("ovr_data_hold", 32'(data_out),    32'h2A5);

      // ---- full released: 0x001 ----
      full = 1'b0;
      p0 = n_push; o0 = n_ovr; q0 = pq_data.size();
      send_frame(10'h001, 1'b1);
      idle(6);
      check("after_full_push", 32'(n_push - p0), 32'd1);
      check("after_full_data", 32'(pq_data[q0]), 32'h001);
      check("after_full_ovr",  32'(n_ovr - o0),  32'd0);

      // ---- back-to-back 0x000, 0x3FF, 0x1AB ----
      p0 = n_push; f0 = n_ferr; q0 = pq_data.size();
      send_frame(10'h000, 1'b1);
      send_frame(10'h3FF, 1'b1);
      send_frame(10'h1AB, 1'b1);
      idle(6);
      check("b2b_push_cnt", 32'(n_push - p0), 32'd3);
      check("b2b_ferr",     32'(n_ferr - f0), 32'd0);
      if (pq_data.size() >= q0 + 3) begin
         check("b2b_data0", 32'(pq_data[q0]),     32'h000);
         check("b2b_data1", 32'(pq_data[q0 + 1]), 32'h3FF);
         check("b2b_data2", 32'(pq_data[q0 + 2]), 32'h1AB);
         check("b2b_gap01", 32'(pq_cyc[q0 + 1] - pq_cyc[q0]),     32'(FRAME));
         check("b2b_gap12", 32'(pq_cyc[q0 + 2] - pq_cyc[q0 + 1]), 32'(FRAME));
      end else begin
         check("b2b_queue_depth", 32'(pq_data.size() - q0), 32'd3);
      end

      // ---- reset during data bit 5, then clean 0x0F0 ----
      p0 = n_push; f0 = n_ferr; o0 = n_ovr;
      send_raw({1'b1, 10'h3C3, 1'b0}, CPB + 5 * CPB + CPB / 2);
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clock);
      check("midrst_push", 32'(push),      32'h0);
      check("midrst_data", 32'(data_out),  32'h0);
      check("midrst_busy", 32'(busy),      32'h0);
      check("midrst_ferr", 32'(frame_err), 32'h0);
      check("midrst_ovr",  32'(overrun),   32'h0);
      @(negedge clock);
      rst = 1'b0;
      idle(FRAME + 20);
      check("midrst_no_push", 32'(n_push - p0), 32'd0);
      check("midrst_no_ferr", 32'(n_ferr - f0), 32'd0);
      check("midrst_no_ovr",  32'(n_ovr - o0),  32'd0);
      q0 = pq_data.size();
      send_frame(10'h0F0, 1'b1);
      idle(6);
      check("post_rst_push", 32'(n_push - p0), 32'd1);
      check("post_rst_data", 32'(data_out),    32'h0F0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
